// File: rtl/ram_param_init_pkg.sv
// Shared constants for the parametrised zero-fill RAM: FSM state encoding,
// access opcodes and the address-width helper used by the sub-blocks.
package ram_param_init_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // A single-word RAM (ADDR_W=0) still carries a 1-bit address bus.
  function automatic int addr_bits(input int aw);
    return (aw > 0) ? aw : 1;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Zero-fill sequencer: IDLE/SWEEP FSM, sweep counter, busy and the
// access-accept / drop decisions for the RAM front end.
module ram_init_seq
  import ram_param_init_pkg::*;
#(
  parameter int   ADDR_W = 2,
  localparam int  AW     = addr_bits(ADDR_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          en,
  output logic          busy,
  output logic          drop,
  output logic          accept,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST = AW'((1 << ADDR_W) - 1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;

  assign busy       = (state == ST_SWEEP);
  assign sweep_we   = busy;
  assign sweep_addr = cnt;
  // INIT wins over a coincident access, and nothing is accepted mid-sweep.
  assign accept     = en && !init && (state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      drop  <= 1'b0;
    end else begin
      // Registered strobe: visible the cycle after the rejected request,
      // aligned with rd_valid and with busy rising.
      drop <= en && !accept;
      case (state)
        ST_IDLE: begin
          if (init) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        default: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_param_init.sv
// Parametrised single-port synchronous RAM with registered read, valid
// strobe and a DEPTH-cycle zero-fill sweep started by INIT.
module ram_param_init
  import ram_param_init_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  ADDR_W = 2,
  localparam int AW     = addr_bits(ADDR_W),
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic              CLK_,
  input  logic              CLR,
  input  logic              EN,
  input  logic              R_W_,
  input  logic [AW-1:0]     ADDR_,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              INIT,
  output logic              busy,
  output logic              drop
);

  localparam logic [AW-1:0] ADDR_MASK = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              sweep_we;
  logic [AW-1:0]     sweep_addr;
  logic [AW-1:0]     addr_eff;

  assign addr_eff = ADDR_ & ADDR_MASK;

  ram_init_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk        (CLK_),
    .rst_n      (CLR),
    .init       (INIT),
    .en         (EN),
    .busy       (busy),
    .drop       (drop),
    .accept     (accept),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // NOTE: the array is cleared by the asynchronous reset on purpose; this
  // forces flop-based storage, which is intended for these small arrays.
  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (sweep_we) begin
        mem[sweep_addr] <= '0;
      end else if (accept && R_W_ == WR) begin
        mem[addr_eff] <= data_in;
      end
      // data_out is touched only by reads; the sweep leaves it alone.
      if (accept && R_W_ == RD) begin
        data_out <= mem[addr_eff];
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_param_init.sv
// Directed self-checking bench for ram_param_init: default 8x4 instance plus
// 1x1 and 16x16 instances for the parameter corners.
module tb_ram_param_init;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Default instance: DATA_W=8, ADDR_W=2
  logic       en = 0, rw = 0, init = 0;
  logic [1:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       rv, busy, drop;

  ram_param_init #(.DATA_W(8), .ADDR_W(2)) dut (
    .CLK_(clk), .CLR(clr), .EN(en), .R_W_(rw), .ADDR_(addr), .data_in(din),
    .data_out(dout), .rd_valid(rv), .INIT(init), .busy(busy), .drop(drop)
  );

  // Single-word instance: DATA_W=1, ADDR_W=0
  logic       s_en = 0, s_rw = 0, s_init = 0;
  logic [0:0] s_addr = '0;
  logic [0:0] s_din = '0;
  logic [0:0] s_dout;
  logic       s_rv, s_busy, s_drop;

  ram_param_init #(.DATA_W(1), .ADDR_W(0)) dut_s (
    .CLK_(clk), .CLR(clr), .EN(s_en), .R_W_(s_rw), .ADDR_(s_addr), .data_in(s_din),
    .data_out(s_dout), .rd_valid(s_rv), .INIT(s_init), .busy(s_busy), .drop(s_drop)
  );

  // Wide instance: DATA_W=16, ADDR_W=4
  logic        b_en = 0, b_rw = 0, b_init = 0;
  logic [3:0]  b_addr = '0;
  logic [15:0] b_din = '0;
  logic [15:0] b_dout;
  logic        b_rv, b_busy, b_drop;

  ram_param_init #(.DATA_W(16), .ADDR_W(4)) dut_b (
    .CLK_(clk), .CLR(clr), .EN(b_en), .R_W_(b_rw), .ADDR_(b_addr), .data_in(b_din),
    .data_out(b_dout), .rd_valid(b_rv), .INIT(b_init), .busy(b_busy), .drop(b_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    en = 1; rw = 0; addr = a; din = d;
    tick();
    en = 0;
    check("wr_no_valid", rv, 0);
  endtask

  task automatic do_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    en = 1; rw = 1; addr = a;
    tick();
    en = 0;
    check(tag, dout, exp);
    check({tag, "_valid"}, rv, 1);
    tick();
    check({tag, "_valid_end"}, rv, 0);
  endtask

  // Counts cycles with busy high, starting from the current sample.
  task automatic count_busy(input string tag, input int exp);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check(tag, n, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset values, write/read round trip with 1-cycle latency
    #1 clr = 0;
    tick(); tick();
    check("rst_dout", dout, 0);
    check("rst_valid", rv, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    clr = 1;
    tick();
    do_write(0, 8'hA5);
    do_write(3, 8'h3C);
    do_read("rd0", 0, 8'hA5);
    do_read("rd3", 3, 8'h3C);
    en = 0; rw = 1; addr = 0;
    tick();
    check("idle_hold", dout, 8'h3C);
    check("idle_no_valid", rv, 0);

    // 2. Asynchronous reset mid-cycle after a full fill
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'(i + 1));
    do_read("fill_rd2", 2, 8'h03);
    #2 clr = 0;
    #1;
    check("async_dout", dout, 0);
    check("async_busy", busy, 0);
    clr = 1;
    tick();
    for (int i = 0; i < 4; i++) do_read("clr_rd", 2'(i), 8'h00);

    // 3. Zero-fill sweep lasts DEPTH cycles and leaves data_out alone
    do_write(0, 8'h11); do_write(1, 8'h22); do_write(2, 8'h33); do_write(3, 8'h44);
    do_read("pre_init_rd", 3, 8'h44);
    init = 1;
    tick();
    init = 0;
    check("init_busy", busy, 1);
    count_busy("sweep_len4", 4);
    check("sweep_keeps_dout", dout, 8'h44);
    for (int i = 0; i < 4; i++) do_read("swept_rd", 2'(i), 8'h00);

    // 4. Drops: write coincident with INIT, read and write during busy
    do_write(2, 8'h77);
    do_read("set_dout", 2, 8'h77);
    en = 1; rw = 0; addr = 1; din = 8'hFF; init = 1;
    tick();
    init = 0;
    check("init_wr_drop", drop, 1);
    check("init_wr_busy", busy, 1);
    rw = 1; addr = 1;
    tick();
    en = 0;
    check("busy_rd_drop", drop, 1);
    check("busy_rd_valid", rv, 0);
    check("busy_rd_hold", dout, 8'h77);
    tick();
    check("drop_clears", drop, 0);
    en = 1; rw = 0; addr = 0; din = 8'h5A;
    tick();
    en = 0;
    check("busy_wr_drop", drop, 1);
    tick();
    check("sweep_done", busy, 0);
    do_read("drop_rd0", 0, 8'h00);
    do_read("drop_rd1", 1, 8'h00);

    // 5. Reset at sweep cycle 2 aborts but still clears; fresh sweep after
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'hC0 + 8'(i));
    init = 1;
    tick();
    init = 0;
    tick(); tick();
    #2 clr = 0;
    #1;
    check("abort_busy", busy, 0);
    clr = 1;
    tick();
    check("abort_idle", busy, 0);
    for (int i = 0; i < 4; i++) do_read("abort_rd", 2'(i), 8'h00);
    init = 1;
    tick();
    init = 0;
    count_busy("resweep_len4", 4);

    // 6a. Single-word RAM: 1-cycle sweep
    s_en = 1; s_rw = 0; s_din = 1'b1;
    tick();
    s_rw = 1;
    tick();
    s_en = 0;
    check("s_rd", s_dout, 1);
    check("s_valid", s_rv, 1);
    s_init = 1;
    tick();
    s_init = 0;
    begin
      int n = 0;
      while (s_busy && n < 40) begin n++; tick(); end
      check("s_sweep_len1", n, 1);
    end
    s_en = 1; s_rw = 1;
    tick();
    s_en = 0;
    check("s_swept_rd", s_dout, 0);

    // 6b. 16-word RAM: BEEF@15 round trip, 16-cycle sweep
    b_en = 1; b_rw = 0; b_addr = 15; b_din = 16'hBEEF;
    tick();
    b_addr = 0; b_din = 16'h1234;
    tick();
    b_rw = 1; b_addr = 15;
    tick();
    check("b_rd15", b_dout, 16'hBEEF);
    check("b_valid", b_rv, 1);
    b_addr = 0;
    tick();
    b_en = 0;
    check("b_rd0", b_dout, 16'h1234);
    b_init = 1;
    tick();
    b_init = 0;
    begin
      int n = 0;
      while (b_busy && n < 40) begin n++; tick(); end
      check("b_sweep_len16", n, 16);
    end
    b_en = 1; b_rw = 1; b_addr = 15;
    tick();
    b_en = 0;
    check("b_swept_rd15", b_dout, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
